fp4_e3m0_add_arbiter: RTL and testbench

- Shares one FP4 E3M0 adder datapath among NUM_REQ independent requesters.
- Each requester submits an operand pair over valid/ready. A round-robin arbiter grants one request per cycle.
- The sum is computed combinationally and registered into a single-entry output stage, tagged with the requester id.
- Sits between the TPU lane issue logic and the FP4 accumulate path; it is the only legal user of the FP4 adder.

---
 rtl/fp4_pkg.sv | 51 +++++
 rtl/rr_arbiter.sv | 31 +++
 rtl/fp4_e3m0_add_arbiter.sv | 87 ++++++++
 tb/tb_fp4_e3m0_add_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fp4_pkg.sv
// Shared FP4 E3M0 types and the adder function used by the arbitrated add path.
// Build with FP4_ADD_SAT_EN to clamp same-sign sums at the largest exponent instead of wrapping.
package fp4_pkg;

    localparam int FP4_W = 4;
    localparam int FP4_EXP_W = 3;
    localparam logic [FP4_EXP_W-1:0] FP4_EXP_MAX = 3'd7;

    typedef struct packed {
        logic                 sign;
        logic [FP4_EXP_W-1:0] exp;
    } fp4_e3m0_t;

    typedef struct packed {
`ifdef FP4_ADD_SAT_EN
        logic      sat;
`endif
        fp4_e3m0_t sum;
    } fp4_add_res_t;

    function automatic fp4_add_res_t fp4_e3m0_add(input fp4_e3m0_t a, input fp4_e3m0_t b);
        fp4_add_res_t r;
`ifdef FP4_ADD_SAT_EN
        logic [FP4_EXP_W:0] wide;
`endif
        r = '0;
        if (a.sign == b.sign) begin
            r.sum.sign = a.sign;
`ifdef FP4_ADD_SAT_EN
            wide = {1'b0, a.exp} + {1'b0, b.exp};
            if (wide[FP4_EXP_W]) begin
                r.sum.exp = FP4_EXP_MAX;
                r.sat     = 1'b1;
            end else begin
                r.sum.exp = wide[FP4_EXP_W-1:0];
            end
`else
            r.sum.exp = a.exp + b.exp;
`endif
        end else if (a.exp >= b.exp) begin
            // Equal magnitudes of opposite sign keep a's sign with exponent 0.
            r.sum.sign = a.sign;
            r.sum.exp  = a.exp - b.exp;
        end else begin
            r.sum.sign = b.sign;
            r.sum.exp  = b.exp - a.exp;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr (mod N) wins when en is high.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic found;
    int   j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (en && !found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fp4_e3m0_add_arbiter.sv
// Shares one FP4 E3M0 adder among NUM_REQ requesters via round-robin, with a one-entry tagged output stage.
// Optional FP4_ADD_SAT_EN adds saturating same-sign sums and the rsp_sat flag.
module fp4_e3m0_add_arbiter
    import fp4_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [3:0]             rsp_sum,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
`ifdef FP4_ADD_SAT_EN
    ,
    output logic                   rsp_sat
`endif
);

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               stage_free;
    logic               xfer;
    fp4_e3m0_t          a_sel;
    fp4_e3m0_t          b_sel;
    fp4_add_res_t       res;

    assign stage_free = !rsp_valid || rsp_ready;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .req       (req_valid),
        .en        (stage_free),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);
    assign busy      = rsp_valid | (|req_valid);

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*FP4_W +: FP4_W];
                b_sel = req_b[i*FP4_W +: FP4_W];
            end
        end
    end

    assign res = fp4_e3m0_add(a_sel, b_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
`ifdef FP4_ADD_SAT_EN
            rsp_sat   <= 1'b0;
`endif
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= res.sum;
            rsp_id    <= grant_idx;
`ifdef FP4_ADD_SAT_EN
            rsp_sat   <= res.sat;
`endif
            if (grant_idx == ID_W'(NUM_REQ - 1))
                rr_ptr <= '0;
            else
                rr_ptr <= grant_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp4_e3m0_add_arbiter.sv
// Directed self-checking bench for fp4_e3m0_add_arbiter (NUM_REQ=4).
module tb_fp4_e3m0_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_sum;
    logic [1:0]  rsp_id;
    logic        busy;
`ifdef FP4_ADD_SAT_EN
    logic        rsp_sat;
`endif

    int passed = 0;
    int total  = 0;

    fp4_e3m0_add_arbiter #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef FP4_ADD_SAT_EN
        ,
        .rsp_sat   (rsp_sat)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // Reference sum written on integer magnitudes.
    function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b);
        int ea;
        int eb;
        int s;
        ea = int'(a[2:0]);
        eb = int'(b[2:0]);
        if (a[3] == b[3]) begin
            s = ea + eb;
`ifdef FP4_ADD_SAT_EN
            if (s > 7) s = 7;
`else
            s = s % 8;
`endif
            return {a[3], 3'(s)};
        end
        if (ea >= eb) return {a[3], 3'(ea - eb)};
        return {b[3], 3'(eb - ea)};
    endfunction

    initial begin
        int id;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        step();
        step();
        chk("reset_valid", 32'(rsp_valid), 0);
        chk("reset_sum", 32'(rsp_sum), 0);
        chk("reset_id", 32'(rsp_id), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(req_ready), 0);
        rst_n = 1'b1;

        // Reset mid-burst; requester i adds exp i and exp 1.
        req_a     = {4'h3, 4'h2, 4'h1, 4'h0};
        req_b     = {4'h1, 4'h1, 4'h1, 4'h1};
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'h1);
        step();
        chk("burst_id0", 32'(rsp_id), 0);
        chk("burst_sum0", 32'(rsp_sum), 1);
        step();
        chk("burst_id1", 32'(rsp_id), 1);
        chk("burst_sum1", 32'(rsp_sum), 2);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(rsp_valid), 0);
        chk("async_sum", 32'(rsp_sum), 0);
        chk("async_id", 32'(rsp_id), 0);
        step();
        chk("held_valid", 32'(rsp_valid), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        step();
        chk("post_rst_valid", 32'(rsp_valid), 1);
        chk("post_rst_id", 32'(rsp_id), 0);

        // Round-robin fairness, one response per cycle.
        for (int k = 1; k <= 8; k++) begin
            step();
            id = k % 4;
            chk("rr_valid", 32'(rsp_valid), 1);
            chk("rr_id", 32'(rsp_id), 32'(id));
            chk("rr_sum", 32'(rsp_sum), 32'(id + 1));
        end

        // Backpressure: output holds id 0 / sum 1.
        rsp_ready = 1'b0;
        #1;
        chk("bp_ready0", 32'(req_ready), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_id", 32'(rsp_id), 0);
            chk("bp_sum", 32'(rsp_sum), 1);
            chk("bp_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("drain_grant", 32'(req_ready), 32'h2);
        step();
        chk("drain_id", 32'(rsp_id), 1);
        chk("drain_sum", 32'(rsp_sum), 2);

        // Pointer skip from rr_ptr=2 with requesters 3 and 1.
        req_valid = 4'b1010;
        #1;
        chk("skip_grant3", 32'(req_ready), 32'h8);
        step();
        chk("skip_id3", 32'(rsp_id), 3);
        chk("skip_sum3", 32'(rsp_sum), 4);
        chk("skip_grant1", 32'(req_ready), 32'h2);
        step();
        chk("skip_id1", 32'(rsp_id), 1);
        chk("skip_valid1", 32'(rsp_valid), 1);

        // Idle with rsp_ready high; rr_ptr must stay at 2.
        req_valid = '0;
        #1;
        chk("idle_busy_pre", 32'(busy), 1);
        step();
        chk("idle_valid", 32'(rsp_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        step();
        chk("idle_valid2", 32'(rsp_valid), 0);
        req_valid = 4'hF;
        #1;
        chk("idle_ptr_grant", 32'(req_ready), 32'h4);
        chk("idle_busy_req", 32'(busy), 1);
        step();
        chk("idle_ptr_id", 32'(rsp_id), 2);

        // Arithmetic on requester 0 alone (rr_ptr is 3 here).
        req_valid = 4'b0001;
        req_a = 16'h0003; req_b = 16'h0002;
        step();
        chk("add_3_2_id", 32'(rsp_id), 0);
        chk("add_3_2", 32'(rsp_sum), 32'h5);
        req_a = 16'h0006; req_b = 16'h0003;
        step();
`ifdef FP4_ADD_SAT_EN
        chk("add_6_3_sat", 32'(rsp_sum), 32'h7);
        chk("add_6_3_flag", 32'(rsp_sat), 1);
`else
        chk("add_6_3_wrap", 32'(rsp_sum), 32'h1);
`endif
        req_a = 16'h000A; req_b = 16'h0005;
        step();
        chk("add_A_5", 32'(rsp_sum), 32'h3);
        req_a = 16'h0004; req_b = 16'h000C;
        step();
        chk("add_4_C", 32'(rsp_sum), 32'h0);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                req_a = {12'h000, 4'(a)};
                req_b = {12'h000, 4'(b)};
                step();
                chk($sformatf("sweep_%0h_%0h", a, b), 32'(rsp_sum), 32'(model(4'(a), 4'(b))));
                chk("sweep_valid", 32'(rsp_valid), 1);
            end
        end

        req_valid = '0;
        step();
        chk("end_valid", 32'(rsp_valid), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
